// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - shared types and helpers for the risc16 fetch path
package risc16_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with flush and a registered head entry
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [W-1:0]  head_data
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, remain;
    logic          head_valid_q, head_valid_d;
    logic [W-1:0]  head_data_q, head_data_d;
    logic          push_en, pop_en;

    always_comb begin
        pop_en       = pop && (count_q != '0) && !flush;
        remain       = count_q - CW'(pop_en);
        push_en      = push && !flush && (remain < FULL);
        rd_ptr_d     = rd_ptr_q + AW'(pop_en);
        wr_ptr_d     = wr_ptr_q + AW'(push_en);
        count_d      = remain + CW'(push_en);
        head_valid_d = (count_d != '0);
        // An entry pushed into an otherwise empty FIFO bypasses storage to the head.
        head_data_d  = (push_en && remain == '0) ? push_data : mem_q[rd_ptr_d];
        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
            head_data_d  = head_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count      = count_q;
    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, req/ack memory reads, prefetch FIFO, redirect flush
// Optional statistics counters enabled by defining INSTR_FETCH_STATS_EN.
module instr_fetch
    import risc16_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready
`ifdef INSTR_FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + ADDR_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              push, pop;
    logic [CW-1:0]     count, post_count;
    logic              head_valid;
    logic [EW-1:0]     head_data;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        push       = 1'b0;
        pop        = head_valid && ir_ready;
        post_count = count - CW'(pop) + CW'(1'b1);
        case (state_q)
            IDLE: begin
                if (!redirect_valid && count < FULL) state_d = WAIT;
            end
            WAIT: begin
                if (mem_ack) begin
                    if (redirect_valid) begin
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = (post_count < FULL) ? WAIT : IDLE;
                    end
                end else if (redirect_valid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) pc_d = redirect_pc;
        // The address must stay put while a request (live or stale) is still unanswered.
        mem_addr_d = (state_q != IDLE && !mem_ack) ? mem_addr_q : pc_d;
        mem_req_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({mem_rdata, mem_addr_q}),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir_valid = head_valid;
    assign ir       = head_data[EW-1:ADDR_W];
    assign ir_pc    = head_data[ADDR_W-1:0];

`ifdef INSTR_FETCH_STATS_EN
    logic [31:0] fetched_q, flushed_q, flush_inc;
    logic        stale_drop;

    always_comb begin
        stale_drop = mem_ack && (state_q == DISCARD || (state_q == WAIT && redirect_valid));
        flush_inc  = (redirect_valid ? 32'(count) : 32'd0) + 32'(stale_drop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= sat_add32(fetched_q, 32'(push));
            flushed_q <= sat_add32(flushed_q, flush_inc);
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif

endmodule
